// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST controller: state encoding,
// LFSR taps, MISR polynomial and response width.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RUN     = 3'd2,
        FLUSH   = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int          LFSR_W      = 5;
    localparam int          SIG_W       = 16;
    localparam int          RESP_W      = 9;
    localparam int          INIT_CYCLES = 2;
    localparam logic [4:0]  LFSR_TAPS   = 5'b10100;
    localparam logic [15:0] MISR_POLY   = 16'h1021;

    // Fibonacci step: shift left, feed back the XOR of the tapped bits (4 and 2).
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_controller_if.sv
// Stimulus/response and status bundle between the BIST controller (master)
// and the circuit under test plus its supervisor (slave).
interface bist_controller_if;
    import bist_pkg::*;

    logic              start;
    logic              cut_rst;
    logic              cut_s;
    logic              cut_dv;
    logic              cut_l_in;
    logic [1:0]        cut_test_in;
    logic              cut_fz_L;
    logic              cut_lclk;
    logic [4:0]        cut_read_a;
    logic [1:0]        cut_test_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;

    modport master (
        input  start, cut_fz_L, cut_lclk, cut_read_a, cut_test_out,
        output cut_rst, cut_s, cut_dv, cut_l_in, cut_test_in,
               busy, done, pass, signature
    );

    modport slave (
        output start, cut_fz_L, cut_lclk, cut_read_a, cut_test_out,
        input  cut_rst, cut_s, cut_dv, cut_l_in, cut_test_in,
               busy, done, pass, signature
    );

endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register: Galois shift with polynomial feedback,
// response word XORed into the low bits on every enabled cycle.
module bist_misr
    import bist_pkg::*;
#(
    parameter int            W    = SIG_W,
    parameter logic [W-1:0]  POLY = MISR_POLY,
    parameter int            DW   = RESP_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [W-1:0]  q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_shift;
    logic [W-1:0] w_next;

    assign w_shift = {r_q[W-2:0], 1'b0} ^ (r_q[W-1] ? POLY : '0);
    assign w_next  = w_shift ^ W'(d);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/bist_controller.sv
// Logic BIST sequencer: LFSR stimulus to the CUT, MISR compaction of its
// responses, golden-signature compare. BIST_WEIGHTED_S_EN biases cut_s towards 1.
module bist_controller
    import bist_pkg::*;
#(
    parameter int                N_PATTERNS = 200,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 5'h01,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG = 16'h0000
) (
    input  logic               clock,
    input  logic               reset,
    bist_controller_if.master  bus
);

    localparam logic [15:0]       RUN_LOAD  = 16'(N_PATTERNS - 1);
    localparam logic [15:0]       INIT_LOAD = 16'(INIT_CYCLES - 1);
    // An all-zero seed would lock the LFSR up.
    localparam logic [LFSR_W-1:0] SEED_EFF  = (LFSR_SEED == '0) ? 5'h01 : LFSR_SEED;

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_cnt;
    logic [15:0]         w_cnt_next;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [LFSR_W-1:0]   w_lfsr_next;
    logic                r_pass;
    logic                w_in_run;
    logic                w_s_bit;
    logic                w_misr_clr;
    logic                w_misr_en;
    logic [RESP_W-1:0]   w_resp;
    logic [SIG_W-1:0]    w_sig;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lfsr  <= 5'h01;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_lfsr  <= w_lfsr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_lfsr_next  = r_lfsr;
        unique case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_next = INIT;
                    w_cnt_next   = INIT_LOAD;
                end
            end
            INIT: begin
                w_lfsr_next = SEED_EFF;
                if (r_cnt == '0) begin
                    w_state_next = RUN;
                    w_cnt_next   = RUN_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            RUN: begin
                w_lfsr_next = lfsr_step(r_lfsr);
                if (r_cnt == '0) begin
                    w_state_next = FLUSH;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            FLUSH:   w_state_next = COMPARE;
            COMPARE: w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_in_run = (r_state == RUN);

`ifdef BIST_WEIGHTED_S_EN
    assign w_s_bit = r_lfsr[4] | r_lfsr[0];
`else
    assign w_s_bit = r_lfsr[4];
`endif

    assign bus.cut_rst     = (r_state == INIT);
    assign bus.cut_s       = w_in_run & w_s_bit;
    assign bus.cut_dv      = w_in_run & r_lfsr[3];
    assign bus.cut_l_in    = w_in_run & r_lfsr[2];
    assign bus.cut_test_in = w_in_run ? r_lfsr[1:0] : 2'b00;

    // The CUT answers one cycle late, so the first RUN cycle has nothing to
    // compact and FLUSH picks up the response to the last pattern.
    assign w_resp     = {bus.cut_fz_L, bus.cut_lclk, bus.cut_read_a, bus.cut_test_out};
    assign w_misr_clr = (r_state == INIT);
    assign w_misr_en  = (w_in_run && (r_cnt != RUN_LOAD)) || (r_state == FLUSH);

    bist_misr #(
        .W    (SIG_W),
        .POLY (MISR_POLY),
        .DW   (RESP_W)
    ) u_misr (
        .clock (clock),
        .reset (reset),
        .clr   (w_misr_clr),
        .en    (w_misr_en),
        .d     (w_resp),
        .q     (w_sig)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pass <= 1'b0;
        end else if (r_state == COMPARE) begin
            r_pass <= (w_sig == GOLDEN_SIG);
        end else if (r_state != DONE) begin
            r_pass <= 1'b0;
        end
    end

    assign bus.busy      = (r_state == INIT) || w_in_run ||
                           (r_state == FLUSH) || (r_state == COMPARE);
    assign bus.done      = (r_state == DONE);
    assign bus.pass      = r_pass && (r_state == DONE);
    assign bus.signature = w_sig;

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench: a 4-pattern instance for timing/start handling and a
// 40-pattern instance for stimulus sequence, fault detection and abort.
module tb_bist_controller;
    import bist_pkg::*;

    function automatic logic [4:0] f_lfsr(input logic [4:0] l);
        return {l[3:0], l[4] ^ l[2]};
    endfunction

    function automatic logic [4:0] f_stim(input logic [4:0] l);
`ifdef BIST_WEIGHTED_S_EN
        return {l[4] | l[0], l[3:0]};
`else
        return l;
`endif
    endfunction

    // Registered CUT stand-in: response is a fixed scramble of the stimulus.
    function automatic logic [8:0] f_cut(input logic [4:0] s);
        return {s[4], s[3], s ^ 5'h15, s[1:0] ^ {s[4], s[2]}};
    endfunction

    function automatic logic [15:0] f_misr(input logic [15:0] m, input logic [8:0] r);
        return ({m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000)) ^ {7'b0, r};
    endfunction

    function automatic logic [15:0] f_sig(input int n, input logic [4:0] seed);
        logic [15:0] m;
        logic [4:0]  l;
        m = 16'h0000;
        l = (seed == 5'h00) ? 5'h01 : seed;
        for (int k = 0; k < n; k++) begin
            m = f_misr(m, f_cut(f_stim(l)));
            l = f_lfsr(l);
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD_T = f_sig(4, 5'h01);
    localparam logic [15:0] GOLD_L = f_sig(40, 5'h01);

    logic       clk;
    logic       rst_n;
    logic       rand_resp;
    logic [8:0] flip_l;
    logic [8:0] r_resp_t;
    logic [8:0] r_resp_l;
    logic [4:0] seq [40];

    int n_chk  = 0;
    int n_pass = 0;

    bist_controller_if if_t ();
    bist_controller_if if_l ();

    bist_controller #(
        .N_PATTERNS (4),
        .LFSR_SEED  (5'h01),
        .GOLDEN_SIG (GOLD_T)
    ) dut_t (
        .clock (clk),
        .reset (rst_n),
        .bus   (if_t.master)
    );

    bist_controller #(
        .N_PATTERNS (40),
        .LFSR_SEED  (5'h01),
        .GOLDEN_SIG (GOLD_L)
    ) dut_l (
        .clock (clk),
        .reset (rst_n),
        .bus   (if_l.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  stim_t, stim_l;
    logic [31:0] out_t, out_l;

    assign stim_t = {if_t.cut_s, if_t.cut_dv, if_t.cut_l_in, if_t.cut_test_in};
    assign stim_l = {if_l.cut_s, if_l.cut_dv, if_l.cut_l_in, if_l.cut_test_in};
    assign out_t  = {7'b0, if_t.busy, if_t.done, if_t.pass, if_t.cut_rst, stim_t, if_t.signature};
    assign out_l  = {7'b0, if_l.busy, if_l.done, if_l.pass, if_l.cut_rst, stim_l, if_l.signature};

    always @(posedge clk) begin
        if (rand_resp) begin
            r_resp_t <= 9'($urandom);
            r_resp_l <= 9'($urandom);
        end else begin
            r_resp_t <= if_t.cut_rst ? 9'h000 : f_cut(stim_t);
            r_resp_l <= if_l.cut_rst ? 9'h000 : (f_cut(stim_l) ^ flip_l);
        end
    end

    assign {if_t.cut_fz_L, if_t.cut_lclk, if_t.cut_read_a, if_t.cut_test_out} = r_resp_t;
    assign {if_l.cut_fz_L, if_l.cut_lclk, if_l.cut_read_a, if_l.cut_test_out} = r_resp_l;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Start at cycle 0, then walk cycles 1..10 against the fixed schedule.
    task automatic run_t(input bit poke);
        if_t.start = 1'b1;
        @(negedge clk);
        if_t.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk("t_cut_rst", 32'(if_t.cut_rst), 32'(c <= 2));
            chk("t_busy",    32'(if_t.busy),    32'(c <= 8));
            chk("t_done",    32'(if_t.done),    32'(c >= 9));
            chk("t_pass",    32'(if_t.pass),    32'(c >= 9));
            if (c == 3) chk("t_misr_clr", 32'(if_t.signature), 32'h0);
            if_t.start = poke && (c == 4);
            @(negedge clk);
        end
        if_t.start = 1'b0;
        chk("t_sig", 32'(if_t.signature), 32'(GOLD_T));
    endtask

    task automatic run_l(input bit do_flip, input bit do_abort);
        bit aborted;
        aborted = 1'b0;
        if_l.start = 1'b1;
        @(negedge clk);
        if_l.start = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            if (c >= 3) seq[c-3] = stim_l;
            flip_l = (do_flip && c == 10) ? 9'h004 : 9'h000;
            if (do_abort && c == 5) begin
                rst_n = 1'b0;
                #1;
                chk("abort_outs", out_l, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        flip_l = 9'h000;
        if (aborted) begin
            @(negedge clk);
            chk("abort_idle", out_l, 32'h0);
        end else begin
            chk("l_stim_flush", 32'(stim_l), 32'h0);
            for (int i = 0; i < 20 && !if_l.done; i++) @(negedge clk);
            chk("l_done", 32'(if_l.done), 32'h1);
        end
    endtask

    initial begin
        logic [4:0] lv [6];
        lv[0] = 5'h01; lv[1] = 5'h02; lv[2] = 5'h04;
        lv[3] = 5'h09; lv[4] = 5'h12; lv[5] = 5'h05;

        rst_n      = 1'b0;
        rand_resp  = 1'b1;
        flip_l     = 9'h000;
        if_t.start = 1'b0;
        if_l.start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if_t.start = 1'($urandom);
            if_l.start = 1'($urandom);
            #1;
            chk("rst_hold_t", out_t, 32'h0);
            chk("rst_hold_l", out_l, 32'h0);
        end
        @(negedge clk);
        if_t.start = 1'b0;
        if_l.start = 1'b0;
        rand_resp  = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        chk("rel_t", out_t, 32'h0);
        chk("rel_l", out_l, 32'h0);

        run_t(1'b0);
        run_t(1'b1);

        run_l(1'b0, 1'b0);
        for (int k = 0; k < 6; k++) chk("stim_seq", 32'(seq[k]), 32'(f_stim(lv[k])));
        for (int k = 0; k < 9; k++) chk("stim_period", 32'(seq[k+31]), 32'(seq[k]));
        chk("l_pass", 32'(if_l.pass), 32'h1);
        chk("l_sig", 32'(if_l.signature), 32'(GOLD_L));

        run_l(1'b1, 1'b0);
        chk("flip_pass", 32'(if_l.pass), 32'h0);
        chk("flip_sig_differs", 32'(if_l.signature != GOLD_L), 32'h1);

        run_l(1'b0, 1'b1);
        run_l(1'b0, 1'b0);
        chk("rerun_pass", 32'(if_l.pass), 32'h1);
        chk("rerun_sig", 32'(if_l.signature), 32'(GOLD_L));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
